// File: rtl/fifo_sync_status_pkg.sv
// Shared types and width helpers for the status FIFO.
package fifo_sync_status_pkg;

  localparam int FIFO_MIN_DEPTH = 4;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_status_if.sv
// Producer/consumer bus of the status FIFO; the FIFO side uses the slave modport.
interface fifo_sync_status_if
  import fifo_sync_status_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CW = cnt_width(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, data_in, rd_en, err_clr,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, err_clr,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_status_sdp_ram.sv
// Simple dual-port storage: one write port, one read port that is either
// registered (SYNC_READ=1) or combinational (SYNC_READ=0).
module fifo_sdp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter bit SYNC_READ  = 1'b1,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  generate
    if (SYNC_READ) begin : g_sync_rd
      logic [DATA_WIDTH-1:0] rdata_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
      end
      assign rdata_o = rdata_q;
    end else begin : g_async_rd
      assign rdata_o = mem_q[raddr_i];
    end
  endgenerate

endmodule

// File: rtl/fifo_sync_status.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky error flags.
// Define FIFO_SYNC_STATUS_FWFT_EN for first-word-fall-through reads.
module fifo_sync_status
  import fifo_sync_status_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input logic               clk,
  input logic               rst_n,
  fifo_sync_status_if.slave bus
);

  localparam int AW = addr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  generate
    if (DEPTH < FIFO_MIN_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fifo_sync_status: DEPTH must be a power of two >= 4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("fifo_sync_status: AF_THRESH outside 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("fifo_sync_status: AE_THRESH outside 0..DEPTH-1");
    end
  endgenerate

  logic [CW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;
  fifo_status_t          st;

  // Extra pointer bit lets the difference span 0..DEPTH without a separate counter.
  assign count = wr_ptr_q - rd_ptr_q;

  always_comb begin
    st              = '0;
    st.full         = (count == DEPTH_C);
    st.empty        = (count == '0);
    st.almost_full  = (count >= AF_C);
    st.almost_empty = (count <= AE_C);
    st.overflow     = ovf_q;
    st.underflow    = udf_q;

    wr_acc   = bus.wr_en && !st.full;
    rd_acc   = bus.rd_en && !st.empty;
    wr_ptr_d = wr_acc ? wr_ptr_q + CW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + CW'(1) : rd_ptr_q;

    // A rejected request in the same cycle as err_clr keeps the flag set.
    ovf_d = bus.err_clr ? 1'b0 : ovf_q;
    udf_d = bus.err_clr ? 1'b0 : udf_q;
    if (bus.wr_en && !wr_acc) ovf_d = 1'b1;
    if (bus.rd_en && !rd_acc) udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

`ifdef FIFO_SYNC_STATUS_FWFT_EN
  localparam bit SYNC_RD = 1'b0;
  logic [DATA_WIDTH-1:0] last_head_q;

  // Remember the popped head so data_out stays put while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_head_q <= '0;
    else if (rd_acc) last_head_q <= ram_rdata;
  end
  assign bus.data_out = st.empty ? last_head_q : ram_rdata;
`else
  localparam bit SYNC_RD = 1'b1;
  assign bus.data_out = ram_rdata;
`endif

  fifo_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .SYNC_READ  (SYNC_RD),
    .AW         (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (bus.data_in),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  assign bus.full         = st.full;
  assign bus.empty        = st.empty;
  assign bus.almost_full  = st.almost_full;
  assign bus.almost_empty = st.almost_empty;
  assign bus.overflow     = st.overflow;
  assign bus.underflow    = st.underflow;
  assign bus.count        = count;

endmodule

// File: tb/tb_fifo_sync_status.sv
// Directed bench for fifo_sync_status: queue-based reference model checked every
// cycle, plus hand-computed expectations at key points of each scenario.
module tb_fifo_sync_status;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_sync_status_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  fifo_sync_status #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int txn_n  = 0;

  logic [DW-1:0] mq [$];
  logic          m_ovf  = 1'b0;
  logic          m_udf  = 1'b0;
  logic [DW-1:0] m_last = '0;
  logic          m_wa, m_ra;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t dut=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of stored words plus sticky error bits.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_last = '0;
    end else begin
      m_wa = bus.wr_en && (mq.size() < DEPTH);
      m_ra = bus.rd_en && (mq.size() > 0);
      if (m_ra) m_last = mq.pop_front();
      if (m_wa) mq.push_back(bus.data_in);
      if (bus.err_clr) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (bus.wr_en && !m_wa) m_ovf = 1'b1;
      if (bus.rd_en && !m_ra) m_udf = 1'b1;
    end
  end

  function automatic logic [DW-1:0] exp_dout();
`ifdef FIFO_SYNC_STATUS_FWFT_EN
    return (mq.size() > 0) ? mq[0] : m_last;
`else
    return m_last;
`endif
  endfunction

  always @(negedge clk) begin
    chk("count",        32'(bus.count),        32'(mq.size()));
    chk("empty",        32'(bus.empty),        32'(mq.size() == 0));
    chk("full",         32'(bus.full),         32'(mq.size() == DEPTH));
    chk("almost_full",  32'(bus.almost_full),  32'(mq.size() >= AF));
    chk("almost_empty", 32'(bus.almost_empty), 32'(mq.size() <= AE));
    chk("overflow",     32'(bus.overflow),     32'(m_ovf));
    chk("underflow",    32'(bus.underflow),    32'(m_udf));
    chk("data_out",     32'(bus.data_out),     32'(exp_dout()));
  end

  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    bus.wr_en   = w;
    bus.data_in = d;
    bus.rd_en   = r;
    bus.err_clr = c;
    @(posedge clk);
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
    txn_n++;
    $display("txn %0d wr=%0b din=%02h rd=%0b clr=%0b -> count=%0d dout=%02h ovf=%0b udf=%0b",
             txn_n, w, d, r, c, bus.count, bus.data_out, bus.overflow, bus.underflow);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t dut=running expected=finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bus.wr_en   = 1'b0;
    bus.data_in = '0;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_count",  32'(bus.count), 32'd0);
    chk("rst_empty",  32'(bus.empty), 32'd1);
    chk("rst_ae",     32'(bus.almost_empty), 32'd1);
    chk("rst_full",   32'(bus.full), 32'd0);
    chk("rst_af",     32'(bus.almost_full), 32'd0);
    chk("rst_dout",   32'(bus.data_out), 32'd0);
    rst_n = 1'b1;

    // Reset in the middle of traffic with five words stored.
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("mid_count", 32'(bus.count), 32'd5);
`ifndef FIFO_SYNC_STATUS_FWFT_EN
    chk("mid_dout", 32'(bus.data_out), 32'h31);
`endif
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_count", 32'(bus.count), 32'd0);
    chk("mrst_empty", 32'(bus.empty), 32'd1);
    chk("mrst_ae",    32'(bus.almost_empty), 32'd1);
    chk("mrst_dout",  32'(bus.data_out), 32'd0);
    rst_n = 1'b1;

    // Fill and drain with threshold crossings.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_count", 32'(bus.count), 32'(i));
      chk("fill_ae",    32'(bus.almost_empty), 32'(i <= 2));
      chk("fill_af",    32'(bus.almost_full), 32'(i >= 14));
      chk("fill_full",  32'(bus.full), 32'(i == 16));
    end
    for (int i = 1; i <= 16; i++) begin
`ifdef FIFO_SYNC_STATUS_FWFT_EN
      chk("drain_head", 32'(bus.data_out), 32'(i));
`endif
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef FIFO_SYNC_STATUS_FWFT_EN
      chk("drain_data", 32'(bus.data_out), 32'(i));
`endif
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // Overflow: 18 writes, the last two are dropped.
    for (int i = 1; i <= 18; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 16) chk("ovf_at16", 32'(bus.overflow), 32'd0);
      if (i == 17) chk("ovf_at17", 32'(bus.overflow), 32'd1);
    end
    chk("ovf_count", 32'(bus.count), 32'd16);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(bus.overflow), 32'd0);
    for (int i = 1; i <= 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ovf_last", 32'(bus.data_out), 32'h10);
    chk("ovf_empty", 32'(bus.empty), 32'd1);

    // Underflow on empty; rejected read in the same cycle as clear keeps the flag.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_set",   32'(bus.underflow), 32'd1);
    chk("udf_count", 32'(bus.count), 32'd0);
    chk("udf_dout",  32'(bus.data_out), 32'h10);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("udf_setwins", 32'(bus.underflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("udf_clr", 32'(bus.underflow), 32'd0);

    // Simultaneous traffic at count=8 across the pointer wrap.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 8'(8'h48 + k), 1'b1, 1'b0);
      chk("sim_count", 32'(bus.count), 32'd8);
`ifndef FIFO_SYNC_STATUS_FWFT_EN
      chk("sim_data", 32'(bus.data_out), 32'(8'h40 + k));
`endif
    end
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    chk("sim_full", 32'(bus.full), 32'd1);
    cyc(1'b1, 8'h70, 1'b1, 1'b0);
    chk("full_wr_rd_count", 32'(bus.count), 32'd15);
    chk("full_wr_rd_ovf",   32'(bus.overflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

`ifdef FIFO_SYNC_STATUS_FWFT_EN
    // Head word is presented without a read request.
    for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("fwft_head",  32'(bus.data_out), 32'hA5);
    chk("fwft_empty", 32'(bus.empty), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_pop", 32'(bus.empty), 32'd1);
`endif

    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
